// File: rtl/hilo_pkg.sv
// Shared opcode encodings and width helpers for the HI/LO accumulate unit.
// HILO_ACC_EN enables the ACC_ADD/ACC_SUB opcodes; when undefined they decode as NOP.
package hilo_pkg;

    typedef logic [2:0] hilo_op_t;

    localparam hilo_op_t HILO_OP_NOP     = 3'd0;
    localparam hilo_op_t HILO_OP_WR_HI   = 3'd1;
    localparam hilo_op_t HILO_OP_WR_LO   = 3'd2;
    localparam hilo_op_t HILO_OP_WR_BOTH = 3'd3;
    localparam hilo_op_t HILO_OP_WR_PROD = 3'd4;
    localparam hilo_op_t HILO_OP_ACC_ADD = 3'd5;
    localparam hilo_op_t HILO_OP_ACC_SUB = 3'd6;
    localparam hilo_op_t HILO_OP_RSVD    = 3'd7;

    // Architectural {HI,LO} width for a given half width.
    function automatic int hilo_w(input int data_w);
        return 2 * data_w;
    endfunction

    // True for opcodes that occupy the pending stage; everything else is a NOP.
    function automatic logic hilo_op_active(input hilo_op_t op);
        logic act;
        case (op)
            HILO_OP_WR_HI,
            HILO_OP_WR_LO,
            HILO_OP_WR_BOTH,
            HILO_OP_WR_PROD: act = 1'b1;
`ifdef HILO_ACC_EN
            HILO_OP_ACC_ADD,
            HILO_OP_ACC_SUB: act = 1'b1;
`endif
            default:         act = 1'b0;
        endcase
        return act;
    endfunction

endpackage

// File: rtl/hilo_acc_unit_if.sv
// Request/response bundle between the pipeline control and the HI/LO unit.
// Pipeline control holds the master side; hilo_acc_unit holds the slave side.
interface hilo_acc_unit_if #(
    parameter int DATA_W = 32
);
    import hilo_pkg::*;

    logic                  stall;
    logic                  flush;
    logic                  req_valid;
    hilo_op_t              req_op;
    logic [DATA_W-1:0]     req_hi;
    logic [DATA_W-1:0]     req_lo;
    logic [2*DATA_W-1:0]   req_prod;
    logic [2*DATA_W-1:0]   hilo_out;
    logic [2*DATA_W-1:0]   hilo_fwd;
    logic                  busy;

    modport master (
        output stall,
        output flush,
        output req_valid,
        output req_op,
        output req_hi,
        output req_lo,
        output req_prod,
        input  hilo_out,
        input  hilo_fwd,
        input  busy
    );

    modport slave (
        input  stall,
        input  flush,
        input  req_valid,
        input  req_op,
        input  req_hi,
        input  req_lo,
        input  req_prod,
        output hilo_out,
        output hilo_fwd,
        output busy
    );

endinterface

// File: rtl/hilo_acc_alu.sv
// Next-value function for {HI,LO}: shared by the commit path and the forwarding path.
// The 2*DATA_W adder/subtractor only exists when HILO_ACC_EN is defined.
module hilo_acc_alu
    import hilo_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  hilo_op_t              op,
    input  logic [2*DATA_W-1:0]   hilo,
    input  logic [DATA_W-1:0]     hi,
    input  logic [DATA_W-1:0]     lo,
    input  logic [2*DATA_W-1:0]   prod,
    output logic [2*DATA_W-1:0]   next_hilo
);

    always_comb begin
        next_hilo = hilo;
        case (op)
            HILO_OP_WR_HI:   next_hilo = {hi, hilo[DATA_W-1:0]};
            HILO_OP_WR_LO:   next_hilo = {hilo[2*DATA_W-1:DATA_W], lo};
            HILO_OP_WR_BOTH: next_hilo = {hi, lo};
            HILO_OP_WR_PROD: next_hilo = prod;
`ifdef HILO_ACC_EN
            // Modulo 2^(2*DATA_W); signedness was already resolved by the multiplier.
            HILO_OP_ACC_ADD: next_hilo = hilo + prod;
            HILO_OP_ACC_SUB: next_hilo = hilo - prod;
`endif
            default:         next_hilo = hilo;
        endcase
    end

endmodule

// File: rtl/hilo_acc_unit.sv
// HI/LO register unit: one pending stage in front of the architectural {HI,LO}.
// Optional HILO_ACC_EN adds MADD/MSUB-style accumulate (ops 5/6).
module hilo_acc_unit
    import hilo_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    hilo_acc_unit_if.slave    bus
);

    localparam int HILO_W = hilo_w(DATA_W);

    logic [HILO_W-1:0]  hilo_reg;
    logic [HILO_W-1:0]  alu_next;
    logic               pend_valid;
    hilo_op_t           pend_op;
    logic [DATA_W-1:0]  pend_hi;
    logic [DATA_W-1:0]  pend_lo;
    logic [HILO_W-1:0]  pend_prod;
    logic               issue;

    assign issue = bus.req_valid && !bus.stall && !bus.flush && hilo_op_active(bus.req_op);

    hilo_acc_alu #(
        .DATA_W    (DATA_W)
    ) u_alu (
        .op        (pend_op),
        .hilo      (hilo_reg),
        .hi        (pend_hi),
        .lo        (pend_lo),
        .prod      (pend_prod),
        .next_hilo (alu_next)
    );

    // A new op can be accepted on the same edge that commits the previous one,
    // so chained accumulates see the already-updated hilo_reg with no bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            hilo_reg   <= '0;
            pend_valid <= 1'b0;
            pend_op    <= HILO_OP_NOP;
            pend_hi    <= '0;
            pend_lo    <= '0;
            pend_prod  <= '0;
        end else if (bus.flush) begin
            pend_valid <= 1'b0;
        end else if (!bus.stall) begin
            if (pend_valid) begin
                hilo_reg <= alu_next;
            end
            pend_valid <= issue;
            if (issue) begin
                pend_op   <= bus.req_op;
                pend_hi   <= bus.req_hi;
                pend_lo   <= bus.req_lo;
                pend_prod <= bus.req_prod;
            end
        end
    end

    assign bus.hilo_out = hilo_reg;
    assign bus.hilo_fwd = pend_valid ? alu_next : hilo_reg;
    assign bus.busy     = pend_valid;

endmodule

// File: tb/tb_hilo_acc_unit.sv
// Scoreboarded random + directed bench for hilo_acc_unit against a spec-level model.
// Honours HILO_ACC_EN so the same bench covers both builds.
module tb_hilo_acc_unit;
    import hilo_pkg::*;

    localparam int DW = 32;

`ifdef HILO_ACC_EN
    localparam bit ACC = 1'b1;
`else
    localparam bit ACC = 1'b0;
`endif

    typedef struct {
        logic [63:0] out;
        logic [63:0] fwd;
        logic        busy;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hilo_acc_unit_if #(.DATA_W(DW)) bus ();

    hilo_acc_unit #(.DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_errors = 0;
    exp_t exp_q[$];

    // Reference model state: committed value plus at most one outstanding op.
    logic [63:0] m_arch;
    logic        m_pv;
    logic [2:0]  m_op;
    logic [31:0] m_hi, m_lo;
    logic [63:0] m_prod;

    function automatic bit model_accepts(input logic [2:0] op);
        if (op >= 3'd1 && op <= 3'd4) return 1'b1;
        if (ACC && (op == 3'd5 || op == 3'd6)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [63:0] model_apply(input logic [2:0] op, input logic [63:0] arch,
                                                input logic [31:0] hi, input logic [31:0] lo,
                                                input logic [63:0] prod);
        logic [63:0] lo_mask;
        lo_mask = 64'h0000_0000_FFFF_FFFF;
        case (op)
            3'd1: return (64'(hi) << 32) | (arch & lo_mask);
            3'd2: return (arch & ~lo_mask) | 64'(lo);
            3'd3: return (64'(hi) << 32) | 64'(lo);
            3'd4: return prod;
            3'd5: return ACC ? arch + prod : arch;
            3'd6: return ACC ? arch - prod : arch;
            default: return arch;
        endcase
    endfunction

    // Drive one cycle of inputs, advance the model across the edge, queue the expectation.
    task automatic step(input logic r, input logic st, input logic fl, input logic v,
                        input logic [2:0] op, input logic [31:0] hi, input logic [31:0] lo,
                        input logic [63:0] prod);
        exp_t e;
        rst           = r;
        bus.stall     = st;
        bus.flush     = fl;
        bus.req_valid = v;
        bus.req_op    = op;
        bus.req_hi    = hi;
        bus.req_lo    = lo;
        bus.req_prod  = prod;
        if (r) begin
            m_arch = 64'd0;
            m_pv   = 1'b0;
        end else if (fl) begin
            m_pv = 1'b0;
        end else if (!st) begin
            if (m_pv) m_arch = model_apply(m_op, m_arch, m_hi, m_lo, m_prod);
            m_pv = v && model_accepts(op);
            if (m_pv) begin
                m_op = op; m_hi = hi; m_lo = lo; m_prod = prod;
            end
        end
        @(posedge clk);
        #1;
        e.out  = m_arch;
        e.fwd  = m_pv ? model_apply(m_op, m_arch, m_hi, m_lo, m_prod) : m_arch;
        e.busy = m_pv;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 64'd0);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: outputs are presented every cycle; compare against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_hilo_out", bus.hilo_out, e.out);
                chk("sb_hilo_fwd", bus.hilo_fwd, e.fwd);
                chk("sb_busy", 64'(bus.busy), 64'(e.busy));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] prev;
        logic [2:0]  rop;
        logic [63:0] rprod;

        // Reset
        step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 64'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 64'd0);
        chk("rst_out", bus.hilo_out, 64'd0);
        chk("rst_fwd", bus.hilo_fwd, 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);

        // WR_BOTH then WR_LO back-to-back
        step(1'b0, 1'b0, 1'b0, 1'b1, HILO_OP_WR_BOTH, 32'h1111_1111, 32'h2222_2222, 64'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1, HILO_OP_WR_LO, 32'h0, 32'h3333_3333, 64'd0);
        idle();
        chk("wr_lo_keeps_hi", bus.hilo_out, 64'h1111_1111_3333_3333);

        // Carry across LO
        step(1'b0, 1'b0, 1'b0, 1'b1, HILO_OP_WR_PROD, 32'd0, 32'd0, 64'h0000_0001_FFFF_FFFF);
        step(1'b0, 1'b0, 1'b0, 1'b1, HILO_OP_ACC_ADD, 32'd0, 32'd0, 64'd1);
        idle();
        chk("acc_carry", bus.hilo_out, ACC ? 64'h0000_0002_0000_0000 : 64'h0000_0001_FFFF_FFFF);

        // Subtract wrap from zero
        step(1'b0, 1'b0, 1'b0, 1'b1, HILO_OP_WR_BOTH, 32'd0, 32'd0, 64'd0);
        idle();
        step(1'b0, 1'b0, 1'b0, 1'b1, HILO_OP_ACC_SUB, 32'd0, 32'd0, 64'd1);
        idle();
        chk("acc_sub_wrap", bus.hilo_out, ACC ? 64'hFFFF_FFFF_FFFF_FFFF : 64'd0);
        prev = ACC ? 64'hFFFF_FFFF_FFFF_FFFF : 64'd0;

        // Flush drops the pending WR_HI
        step(1'b0, 1'b0, 1'b0, 1'b1, HILO_OP_WR_HI, 32'hDEAD_BEEF, 32'd0, 64'd0);
        chk("flush_pre_fwd", bus.hilo_fwd, {32'hDEAD_BEEF, prev[31:0]});
        step(1'b0, 1'b0, 1'b1, 1'b1, HILO_OP_WR_BOTH, 32'h5555_5555, 32'h6666_6666, 64'd0);
        chk("flush_out", bus.hilo_out, prev);
        chk("flush_busy", 64'(bus.busy), 64'd0);
        chk("flush_fwd", bus.hilo_fwd, prev);
        idle();
        chk("flush_no_commit", bus.hilo_out, prev);

        // Stall holds a pending ACC_ADD; requests during stall are ignored
        step(1'b0, 1'b0, 1'b0, 1'b1, HILO_OP_WR_PROD, 32'd0, 32'd0, 64'h0000_0005_0000_0007);
        idle();
        step(1'b0, 1'b0, 1'b0, 1'b1, HILO_OP_ACC_ADD, 32'd0, 32'd0, 64'd3);
        repeat (3) step(1'b0, 1'b1, 1'b0, 1'b1, HILO_OP_WR_BOTH, 32'h7777_7777, 32'h8888_8888, 64'd0);
        chk("stall_out", bus.hilo_out, 64'h0000_0005_0000_0007);
        chk("stall_busy", 64'(bus.busy), ACC ? 64'd1 : 64'd0);
        chk("stall_fwd", bus.hilo_fwd, ACC ? 64'h0000_0005_0000_000A : 64'h0000_0005_0000_0007);
        idle();
        chk("stall_release_commit", bus.hilo_out, ACC ? 64'h0000_0005_0000_000A : 64'h0000_0005_0000_0007);
        chk("stall_release_busy", 64'(bus.busy), 64'd0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            rop = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: rprod = 64'hFFFF_FFFF_FFFF_FFFF;
                1: rprod = 64'(32'hFFFF_FFFF);
                default: rprod = {$urandom, $urandom};
            endcase
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0),
                 rop, $urandom, $urandom, rprod);
        end
        idle();

        repeat (2) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL sb_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
